// File: rtl/c_readout.sv
// Streams result matrix C out of its memory in row-major order over valid/ready.
// A 2-entry skid buffer hides the 1-cycle memory read latency under backpressure.
module c_readout #(
  parameter int MATRIX_DIM = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  re_c,
  output logic [ADDR_WIDTH-1:0] addr_rd_c,
  input  logic [DATA_WIDTH-1:0] rd_data_c,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);
  localparam int NUM_ELEM = MATRIX_DIM * MATRIX_DIM;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ELEM - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]                 r_state;
  logic [ADDR_WIDTH-1:0]      r_cnt;
  logic                       r_inflight;
  logic                       r_inflight_last;
  logic [1:0]                 r_occ;
  logic [1:0][DATA_WIDTH-1:0] r_buf_data;
  logic [1:0]                 r_buf_last;
  logic                       r_done;

  logic       w_pop;
  logic       w_push;
  logic [1:0] w_slot;

  // w_slot is the occupancy left after this cycle's pop; it is both the write
  // slot for returning data and the basis for read credit, so a pop frees room
  // for a new read in the same cycle and full rate is sustained.
  assign w_pop  = (r_occ != 2'd0) && m_ready;
  assign w_push = r_inflight;
  assign w_slot = r_occ - {1'b0, w_pop};

  assign re_c      = (r_state == S_READ) && ((w_slot + {1'b0, r_inflight}) < 2'd2);
  assign addr_rd_c = r_cnt;
  assign m_valid   = (r_occ != 2'd0);
  assign m_data    = r_buf_data[0];
  assign m_last    = r_buf_last[0] && m_valid;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= re_c;
      r_inflight_last <= re_c && (r_cnt == LAST_ADDR);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_READ;
            r_cnt   <= '0;
          end
        end
        S_READ: begin
          if (re_c) begin
            if (r_cnt == LAST_ADDR) r_state <= S_DRAIN;
            else                    r_cnt   <= r_cnt + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (w_pop && r_buf_last[0] && (r_occ == 2'd1) && !r_inflight) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Head is always entry 0; a pop shifts entry 1 down, and the returning word
  // lands behind whatever survives the pop.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_occ      <= 2'd0;
      r_buf_data <= '0;
      r_buf_last <= '0;
    end else begin
      r_occ <= w_slot + {1'b0, w_push};
      if (w_pop) begin
        r_buf_data[0] <= r_buf_data[1];
        r_buf_last[0] <= r_buf_last[1];
      end
      if (w_push) begin
        if (w_slot == 2'd0) begin
          r_buf_data[0] <= rd_data_c;
          r_buf_last[0] <= r_inflight_last;
        end else begin
          r_buf_data[1] <= rd_data_c;
          r_buf_last[1] <= r_inflight_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_c_readout.sv
// Bench for c_readout: memory model, random backpressure, and a stream
// scoreboard that expects mem[0..N-1] in order with last on the final element.
module tb_c_readout;
  localparam int MD = 8;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int N  = MD * MD;

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          m_ready = 1'b1;
  logic          re_c, m_valid, m_last, busy, done;
  logic [AW-1:0] addr_rd_c;
  logic [DW-1:0] rd_data_c, m_data;
  logic [DW-1:0] mem [N];

  int n_chk = 0, n_err = 0;
  int idx = 0, outst = 0, n_xfer = 0, n_dpulse = 0, rdy_mode = 0, ph = 0;
  bit prev_stall = 0, done_due = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  c_readout #(.MATRIX_DIM(MD), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .re_c(re_c), .addr_rd_c(addr_rd_c),
    .rd_data_c(rd_data_c), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // Synchronous memory; junk on the data bus when no read was issued.
  always @(posedge CLK) rd_data_c <= re_c ? mem[addr_rd_c] : $urandom;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK); #1;
      case (rdy_mode)
        1:       m_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      ph++;
    end
  end

  // Scoreboard: transfers must walk mem[] in order; done follows the final one.
  always @(negedge CLK) begin
    if (!rst_n) begin
      idx = 0; outst = 0; prev_stall = 0; done_due = 0;
    end else begin
      if (done) n_dpulse++;
      chk("done_pulse", done, done_due);
      if (done_due) chk("busy_in_done", busy, 0);
      done_due = 0;
      if (!busy) chk("re_idle", re_c, 0);
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
        chk("hold_last", m_last, prev_last);
      end
      if (re_c) chk("re_room", (outst - int'(m_valid && m_ready)) < 2, 1);
      if (m_valid && m_ready) begin
        chk("data", m_data, mem[idx]);
        chk("last", m_last, idx == N - 1);
        n_xfer++;
        outst--;
        if (idx == N - 1) begin idx = 0; done_due = 1; end
        else idx++;
      end
      if (re_c) outst++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic start_pulse();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // Counts edges after the start-sampling edge: first m_valid and the done cycle.
  task automatic run_until_done(output int first_v, output int n_edges);
    first_v = -1;
    n_edges = -1;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge CLK); #1;
      if (m_valid && first_v < 0) first_v = k;
      if (done) begin n_edges = k; break; end
    end
    if (n_edges < 0) chk("done_timeout", done, 1);
  endtask

  task automatic wait_xfer(input int target);
    int k;
    k = 0;
    while (n_xfer < target && k < 2000) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("xfer_reach", n_xfer >= target, 1);
  endtask

  task automatic settle_and_count(input string tag, input int b, input int bd, input int nx, input int nd);
    repeat (4) @(posedge CLK);
    #1;
    chk({tag, "_xfers"}, n_xfer - b, nx);
    chk({tag, "_dones"}, n_dpulse - bd, nd);
    chk({tag, "_idle"}, {busy, m_valid}, 0);
  endtask

  initial begin
    int fv, ne, b, bd;
    for (int i = 0; i < N; i++) mem[i] = 100 + i;

    // Reset, then idle with no start
    #1 chk("reset_outs", {re_c, addr_rd_c, m_valid, m_last, m_data, busy, done}, 0);
    repeat (3) @(posedge CLK);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK); #1;
      chk("idle_outs", {re_c, addr_rd_c, m_valid, m_last, m_data, busy, done}, 0);
    end

    // Full rate
    b = n_xfer; bd = n_dpulse;
    start_pulse();
    chk("busy_after_start", busy, 1);
    run_until_done(fv, ne);
    chk("first_valid_lat", fv, 2);
    chk("fullrate_done_cycle", ne, N + 2);
    chk("busy_low_in_done", busy, 0);
    settle_and_count("fullrate", b, bd, N, 1);

    // Backpressure 1,0,0,1
    rdy_mode = 1;
    b = n_xfer; bd = n_dpulse;
    start_pulse();
    run_until_done(fv, ne);
    chk("bp_first_valid_lat", fv, 2);
    settle_and_count("bp", b, bd, N, 1);

    // Start while busy, at transfer 10
    rdy_mode = 0;
    b = n_xfer; bd = n_dpulse;
    start_pulse();
    wait_xfer(b + 10);
    start_pulse();
    run_until_done(fv, ne);
    settle_and_count("start_busy", b, bd, N, 1);

    // Back-to-back: start raised in the done cycle
    b = n_xfer; bd = n_dpulse;
    start_pulse();
    run_until_done(fv, ne);
    start_pulse();
    chk("b2b_busy", busy, 1);
    run_until_done(fv, ne);
    chk("b2b_first_valid_lat", fv, 2);
    chk("b2b_done_cycle", ne, N + 2);
    settle_and_count("b2b", b, bd, 2 * N, 2);

    // Reset mid-readout after transfer 30
    rdy_mode = 1;
    start_pulse();
    wait_xfer(n_xfer + 30);
    rst_n = 1'b0;
    #1 chk("rst_mid_outs", {m_valid, busy, re_c, done}, 0);
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;
    b = n_xfer; bd = n_dpulse;
    start_pulse();
    run_until_done(fv, ne);
    settle_and_count("after_rst", b, bd, N, 1);

    // Random data, random backpressure, random stray start while busy
    rdy_mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) mem[i] = $urandom;
      b = n_xfer; bd = n_dpulse;
      start_pulse();
      repeat ($urandom_range(0, 40)) @(posedge CLK);
      #1 start_pulse();
      run_until_done(fv, ne);
      settle_and_count("rand", b, bd, N, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/c_readout.md
Name: c_readout

Overview:
- Reader for the result matrix C after the matrix-multiply sequencer has written it.
- On a start pulse it walks C memory in row-major order (addresses 0 to MATRIX_DIM**2-1). It issues synchronous reads and streams each element out on a valid/ready interface, marking the final element with m_last.
- A 2-entry output buffer absorbs the 1-cycle memory read latency, so downstream backpressure never loses or duplicates data.

Parameters:
- MATRIX_DIM, 8, matrix side length; C holds MATRIX_DIM**2 elements.
- ADDR_WIDTH, 6, C memory address width; must satisfy 2**ADDR_WIDTH >= MATRIX_DIM**2.
- DATA_WIDTH, 32, width of one C element (MAC accumulator width).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a readout; ignored while busy=1.
- re_c  output  1  C memory read enable.
- addr_rd_c  output  ADDR_WIDTH  C memory read address.
- rd_data_c  input  DATA_WIDTH  C memory read data, valid exactly 1 cycle after re_c=1.
- m_data  output  DATA_WIDTH  stream data.
- m_valid  output  1  stream data valid.
- m_ready  input  1  downstream ready; a transfer occurs when m_valid && m_ready.
- m_last  output  1  high with m_valid on the element at address MATRIX_DIM**2-1.
- busy  output  1  high from the cycle after an accepted start until the last transfer completes.
- done  output  1  one-cycle pulse in the cycle after the last transfer.

Behaviour:
Reset (rst_n=0, asynchronous):
- State goes to IDLE; the read address counter and issued count are 0.
- Buffer is empty, with no read in flight.
- re_c=0, addr_rd_c=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0.

States:
- IDLE: start=1 -> READ; the read counter is cleared to 0.
- READ: issue reads. When the read for address MATRIX_DIM**2-1 is issued -> DRAIN.
- DRAIN: no new reads. When the buffer is empty, no read is in flight, and the last transfer has completed -> IDLE, with done=1 for one cycle.

Read issue rule:
- re_c=1 in READ only when (buffer occupancy + reads in flight) < 2.
- addr_rd_c is the current read counter. The counter increments by 1 on each issued read.
- re_c is combinational from registered state; no read is issued in the same cycle start is sampled.

Return path:
- The cycle after re_c=1, rd_data_c is written into the buffer tail.
- m_data/m_valid always present the buffer head.
- Simultaneous write and pop in one cycle: occupancy is unchanged and ordering is preserved.

Backpressure and protocol rules:
- m_ready=0 holds m_data, m_valid and m_last stable; no element is dropped or duplicated.
- With m_ready held at 1, sustained throughput is 1 element/cycle after the first element.
- First-element latency: m_valid rises 2 cycles after the start pulse (1 cycle to enter READ, 1 cycle read latency).

m_last and completion:
- m_last is tracked per buffer entry, set when the entry's address is MATRIX_DIM**2-1.
- A start while busy=1 is ignored (no restart, no counter change).
- A start in the same cycle as done is accepted and begins a new readout.
- busy is 0 in the done cycle.

Reset mid-operation:
- Asserting rst_n=0 at any point returns all state to reset values immediately.
- The in-flight read is discarded and the buffered data is lost.

Widths:
- The read counter is ADDR_WIDTH bits and never wraps within a readout; it stops at MATRIX_DIM**2-1.
- Total elements streamed per start: exactly MATRIX_DIM**2.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles then 1, no start -> all outputs 0 for 20 cycles; re_c never asserted.
- Full-rate readout: C[i]=i+100, start pulse, m_ready=1 -> m_valid rises 2 cycles after start. m_data streams 100..163 on 64 consecutive cycles; m_last only with 163; done pulses 1 cycle after; busy=0 in the done cycle.
- Backpressure: m_ready toggles 1,0,0,1 repeating -> 64 transfers in order 100..163, no duplicates. m_data stays stable while m_ready=0. At most 2 elements are buffered, and re_c=0 whenever occupancy+in-flight=2.
- Start while busy: second start pulse at transfer 10 -> ignored; exactly 64 transfers and one done pulse.
- Back-to-back: start asserted in the done cycle -> a second complete 64-element readout follows with identical data and m_last placement.
- Reset mid-readout: rst_n=0 after transfer 30, then release and start -> m_valid drops immediately on reset. The new readout begins at address 0 (m_data=100) and completes 64 transfers.
